// File: rtl/data_mem_arb_pkg.sv
// Shared encodings for the data-memory arbiter: FSM states, port ids and timeout fill data.
package data_mem_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_BUSY  = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   localparam logic PORT_CPU = 1'b0;
   localparam logic PORT_DMA = 1'b1;

   localparam logic [31:0] TIMEOUT_DATA = 32'hDEADBEEF;

endpackage

// File: rtl/data_mem_arb_pick.sv
// Combinational winner select: port 0 has priority unless port 1 has waited STARVE_LIMIT grants.
module data_mem_arb_pick
   import data_mem_arb_pkg::*;
#(
   parameter int STARVE_LIMIT = 4,
   parameter int CNT_W        = 3
) (
   input  logic             m0_req,
   input  logic             m1_req,
   input  logic [CNT_W-1:0] starve_cnt,
   output logic             pick
);

   always_comb begin
      pick = PORT_CPU;
      if (m1_req && (!m0_req || starve_cnt == CNT_W'(STARVE_LIMIT)))
         pick = PORT_DMA;
   end

endmodule

// File: rtl/data_mem_arbiter.sv
// Two-port arbiter onto the strobe/stall data memory; read ack 4 edges after grant, write 3.
// Requesters hold req until ack; optional BUSY watchdog under DATA_MEM_ARB_TIMEOUT_EN.
module data_mem_arbiter
   import data_mem_arb_pkg::*;
#(
   parameter int STARVE_LIMIT   = 4,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        m0_req,
   input  logic        m0_wr,
   input  logic [31:0] m0_addr,
   input  logic [31:0] m0_wdata,
   input  logic [3:0]  m0_mask,
   output logic [31:0] m0_rdata,
   output logic        m0_ack,
   output logic        m0_err,
   input  logic        m1_req,
   input  logic        m1_wr,
   input  logic [31:0] m1_addr,
   input  logic [31:0] m1_wdata,
   input  logic [3:0]  m1_mask,
   output logic [31:0] m1_rdata,
   output logic        m1_ack,
   output logic        m1_err,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_write_data,
   output logic        mem_memread,
   output logic        mem_memwrite,
   output logic [3:0]  mem_sign_mask,
   input  logic [31:0] mem_read_data,
   input  logic        mem_clk_stall
);

   localparam int               CNT_W      = $clog2(STARVE_LIMIT + 1);
   localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

   if (STARVE_LIMIT < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
      $error("data_mem_arbiter: STARVE_LIMIT and TIMEOUT_CYCLES must be >= 1");
   end

   state_t           state;
   logic             grant;
   logic             op_wr;
   logic [CNT_W-1:0] starve_cnt;
   logic             pick;

   data_mem_arb_pick #(
      .STARVE_LIMIT (STARVE_LIMIT),
      .CNT_W        (CNT_W)
   ) u_pick (
      .m0_req     (m0_req),
      .m1_req     (m1_req),
      .starve_cnt (starve_cnt),
      .pick       (pick)
   );

`ifdef DATA_MEM_ARB_TIMEOUT_EN
   localparam int            TO_W   = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_CYCLES - 1);
   logic [TO_W-1:0] busy_cnt;
`else
   assign m0_err = 1'b0;
   assign m1_err = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= ST_IDLE;
         grant          <= PORT_CPU;
         op_wr          <= 1'b0;
         starve_cnt     <= '0;
         mem_addr       <= '0;
         mem_write_data <= '0;
         mem_sign_mask  <= '0;
         mem_memread    <= 1'b0;
         mem_memwrite   <= 1'b0;
         m0_rdata       <= '0;
         m1_rdata       <= '0;
         m0_ack         <= 1'b0;
         m1_ack         <= 1'b0;
`ifdef DATA_MEM_ARB_TIMEOUT_EN
         m0_err         <= 1'b0;
         m1_err         <= 1'b0;
         busy_cnt       <= '0;
`endif
      end else begin
         case (state)
            // Holding off while stalled lets an access orphaned by reset drain first.
            ST_IDLE: begin
               if (!mem_clk_stall && (m0_req || m1_req)) begin
                  grant <= pick;
                  state <= ST_ISSUE;
                  if (pick == PORT_DMA) begin
                     mem_addr       <= m1_addr;
                     mem_write_data <= m1_wdata;
                     mem_sign_mask  <= m1_mask;
                     op_wr          <= m1_wr;
                     mem_memread    <= ~m1_wr;
                     mem_memwrite   <= m1_wr;
                     starve_cnt     <= '0;
                  end else begin
                     mem_addr       <= m0_addr;
                     mem_write_data <= m0_wdata;
                     mem_sign_mask  <= m0_mask;
                     op_wr          <= m0_wr;
                     mem_memread    <= ~m0_wr;
                     mem_memwrite   <= m0_wr;
                     if (m1_req && starve_cnt != STARVE_MAX)
                        starve_cnt <= starve_cnt + 1'b1;
                  end
               end
            end
            ST_ISSUE: begin
               mem_memread  <= 1'b0;
               mem_memwrite <= 1'b0;
               state        <= ST_BUSY;
`ifdef DATA_MEM_ARB_TIMEOUT_EN
               busy_cnt     <= '0;
`endif
            end
            ST_BUSY: begin
               if (!mem_clk_stall) begin
                  if (grant == PORT_DMA) begin
                     m1_ack <= 1'b1;
                     if (!op_wr) m1_rdata <= mem_read_data;
                  end else begin
                     m0_ack <= 1'b1;
                     if (!op_wr) m0_rdata <= mem_read_data;
                  end
                  state <= ST_DONE;
               end
`ifdef DATA_MEM_ARB_TIMEOUT_EN
               else if (busy_cnt == TO_MAX) begin
                  if (grant == PORT_DMA) begin
                     m1_ack   <= 1'b1;
                     m1_err   <= 1'b1;
                     m1_rdata <= TIMEOUT_DATA;
                  end else begin
                     m0_ack   <= 1'b1;
                     m0_err   <= 1'b1;
                     m0_rdata <= TIMEOUT_DATA;
                  end
                  state <= ST_DONE;
               end else begin
                  busy_cnt <= busy_cnt + 1'b1;
               end
`endif
            end
            ST_DONE: begin
               m0_ack <= 1'b0;
               m1_ack <= 1'b0;
`ifdef DATA_MEM_ARB_TIMEOUT_EN
               m0_err <= 1'b0;
               m1_err <= 1'b0;
`endif
               state  <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter with a strobe/stall memory responder.
module tb_data_mem_arbiter;

   localparam int STARVE_LIMIT   = 4;
   localparam int TIMEOUT_CYCLES = 8;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        m0_req = 1'b0, m0_wr = 1'b0;
   logic [31:0] m0_addr = '0, m0_wdata = '0;
   logic [3:0]  m0_mask = '0;
   logic [31:0] m0_rdata;
   logic        m0_ack, m0_err;
   logic        m1_req = 1'b0, m1_wr = 1'b0;
   logic [31:0] m1_addr = '0, m1_wdata = '0;
   logic [3:0]  m1_mask = '0;
   logic [31:0] m1_rdata;
   logic        m1_ack, m1_err;
   logic [31:0] mem_addr, mem_write_data, mem_read_data;
   logic        mem_memread, mem_memwrite, mem_clk_stall;
   logic [3:0]  mem_sign_mask;

   int errors = 0;
   int checks = 0;
   int cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Memory responder: stall rises on the strobe-sampling edge; reads stall two cycles, writes one.
   logic        mdl_stall = 1'b0;
   logic [31:0] mdl_rdata = '0;
   int          mdl_cnt = 0;
   logic        hang = 1'b0;
   logic        hold_stall = 1'b0;
   logic [31:0] rd_value = '0;

   always @(posedge clk) begin
      if (mem_memread || mem_memwrite) begin
         mdl_stall <= 1'b1;
         mdl_cnt   <= mem_memread ? 2 : 1;
         mdl_rdata <= 32'h0BAD0BAD;
      end else if (mdl_stall && !hang) begin
         if (mdl_cnt == 1) begin
            mdl_stall <= 1'b0;
            mdl_rdata <= rd_value;
         end
         mdl_cnt <= mdl_cnt - 1;
      end
   end

   assign mem_clk_stall = mdl_stall | hold_stall;
   assign mem_read_data = mdl_rdata;

   data_mem_arbiter #(
      .STARVE_LIMIT   (STARVE_LIMIT),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .m0_req         (m0_req),
      .m0_wr          (m0_wr),
      .m0_addr        (m0_addr),
      .m0_wdata       (m0_wdata),
      .m0_mask        (m0_mask),
      .m0_rdata       (m0_rdata),
      .m0_ack         (m0_ack),
      .m0_err         (m0_err),
      .m1_req         (m1_req),
      .m1_wr          (m1_wr),
      .m1_addr        (m1_addr),
      .m1_wdata       (m1_wdata),
      .m1_mask        (m1_mask),
      .m1_rdata       (m1_rdata),
      .m1_ack         (m1_ack),
      .m1_err         (m1_err),
      .mem_addr       (mem_addr),
      .mem_write_data (mem_write_data),
      .mem_memread    (mem_memread),
      .mem_memwrite   (mem_memwrite),
      .mem_sign_mask  (mem_sign_mask),
      .mem_read_data  (mem_read_data),
      .mem_clk_stall  (mem_clk_stall)
   );

   logic [137:0] all_out;
   assign all_out = {m0_rdata, m0_ack, m0_err, m1_rdata, m1_ack, m1_err, mem_addr,
                     mem_write_data, mem_memread, mem_memwrite, mem_sign_mask};

   int          obs_strobe, obs_ack, obs_lat;
   logic        obs_rd, obs_other, obs_err, obs_err_any;
   logic [31:0] obs_addr, obs_wdata, obs_rdata;
   logic [3:0]  obs_mask;

   task automatic run_txn(input int port, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] mask, input int budget);
      int   grant_cyc = -1;
      int   tail = 2;
      logic own, oth;
      obs_strobe = 0; obs_ack = 0; obs_lat = -1; obs_rd = 1'b0; obs_other = 1'b0;
      obs_err = 1'b0; obs_err_any = 1'b0; obs_addr = '0; obs_wdata = '0; obs_rdata = '0; obs_mask = '0;
      if (port == 0) begin
         m0_req = 1'b1; m0_wr = wr; m0_addr = addr; m0_wdata = wdata; m0_mask = mask;
      end else begin
         m1_req = 1'b1; m1_wr = wr; m1_addr = addr; m1_wdata = wdata; m1_mask = mask;
      end
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (mem_memread || mem_memwrite) begin
            obs_strobe++;
            if (grant_cyc < 0) begin
               grant_cyc = cyc; obs_rd = mem_memread; obs_addr = mem_addr;
               obs_wdata = mem_write_data; obs_mask = mem_sign_mask;
            end
         end
         own = (port == 0) ? m0_ack : m1_ack;
         oth = (port == 0) ? m1_ack : m0_ack;
         if (oth) obs_other = 1'b1;
         if (m0_err || m1_err) obs_err_any = 1'b1;
         if (own) begin
            obs_ack++;
            if (obs_ack == 1) begin
               obs_lat   = (grant_cyc < 0) ? -1 : cyc - grant_cyc;
               obs_rdata = (port == 0) ? m0_rdata : m1_rdata;
               obs_err   = (port == 0) ? m0_err : m1_err;
               if (port == 0) m0_req = 1'b0; else m1_req = 1'b0;
            end
         end
         if (obs_ack > 0) begin
            if (tail == 0) break;
            tail--;
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if (all_out !== '0) begin errors++; $display("FAIL reset_outputs: got %h required 0", all_out); end
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if (all_out !== '0) begin errors++; $display("FAIL idle_outputs: got %h required 0", all_out); end
   endtask

   task automatic test_single_read();
      rd_value = 32'h12345678;
      run_txn(0, 1'b0, 32'h1004, 32'h0, 4'h0, 30);
      checks++; if (obs_strobe !== 1) begin errors++; $display("FAIL rd_strobe_cycles: got %0d required 1", obs_strobe); end
      checks++; if (obs_rd !== 1'b1) begin errors++; $display("FAIL rd_is_memread: got %0b required 1", obs_rd); end
      checks++; if (obs_addr !== 32'h1004) begin errors++; $display("FAIL rd_addr: got %h required 00001004", obs_addr); end
      checks++; if (obs_ack !== 1) begin errors++; $display("FAIL rd_ack_cycles: got %0d required 1", obs_ack); end
      checks++; if (obs_lat !== 4) begin errors++; $display("FAIL rd_latency: got %0d required 4", obs_lat); end
      checks++; if (obs_rdata !== 32'h12345678) begin errors++; $display("FAIL rd_data: got %h required 12345678", obs_rdata); end
      checks++; if (obs_other !== 1'b0) begin errors++; $display("FAIL rd_m1_ack: got %0b required 0", obs_other); end
   endtask

   task automatic test_single_write();
      logic [31:0] prev = m1_rdata;
      run_txn(1, 1'b1, 32'h2000, 32'hA5, 4'b0100, 30);
      checks++; if (obs_strobe !== 1) begin errors++; $display("FAIL wr_strobe_cycles: got %0d required 1", obs_strobe); end
      checks++; if (obs_rd !== 1'b0) begin errors++; $display("FAIL wr_is_memwrite: got memread=%0b required 0", obs_rd); end
      checks++; if (obs_addr !== 32'h2000) begin errors++; $display("FAIL wr_addr: got %h required 00002000", obs_addr); end
      checks++; if (obs_wdata !== 32'hA5) begin errors++; $display("FAIL wr_data: got %h required 000000a5", obs_wdata); end
      checks++; if (obs_mask !== 4'b0100) begin errors++; $display("FAIL wr_mask: got %b required 0100", obs_mask); end
      checks++; if (obs_ack !== 1) begin errors++; $display("FAIL wr_ack_cycles: got %0d required 1", obs_ack); end
      checks++; if (obs_lat !== 3) begin errors++; $display("FAIL wr_latency: got %0d required 3", obs_lat); end
      checks++; if (m1_rdata !== prev) begin errors++; $display("FAIL wr_rdata_held: got %h required %h", m1_rdata, prev); end
      checks++; if (obs_other !== 1'b0) begin errors++; $display("FAIL wr_m0_ack: got %0b required 0", obs_other); end
   endtask

   task automatic test_contention();
      int   order[10];
      int   gcyc[2];
      int   n = 0, g = 0;
      logic both = 1'b0;
      int   exp_order[10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
      for (int i = 0; i < 10; i++) order[i] = 2;
      gcyc[0] = 0; gcyc[1] = 0;
      rd_value = 32'h0000_0C0C;
      m0_wr = 1'b0; m0_addr = 32'h10; m1_wr = 1'b0; m1_addr = 32'h20;
      m0_req = 1'b1; m1_req = 1'b1;
      for (int i = 0; i < 200 && n < 10; i++) begin
         @(negedge clk);
         if ((mem_memread || mem_memwrite) && g < 2) begin gcyc[g] = cyc; g++; end
         if (m0_ack && m1_ack) both = 1'b1;
         if (m0_ack) begin order[n] = 0; n++; end
         else if (m1_ack) begin
            order[n] = 1; n++;
            checks++;
            if (int'(dut.starve_cnt) !== 0) begin errors++; $display("FAIL starve_cleared: got %0d required 0", int'(dut.starve_cnt)); end
         end
      end
      m0_req = 1'b0; m1_req = 1'b0;
      for (int i = 0; i < 10; i++) begin
         checks++;
         if (order[i] !== exp_order[i]) begin errors++; $display("FAIL grant_order[%0d]: got port %0d required port %0d", i, order[i], exp_order[i]); end
      end
      checks++; if (both !== 1'b0) begin errors++; $display("FAIL dual_ack: got 1 required 0"); end
      checks++; if (gcyc[1] - gcyc[0] !== 6) begin errors++; $display("FAIL read_spacing: got %0d required 6", gcyc[1] - gcyc[0]); end
      repeat (4) @(negedge clk);
   endtask

   task automatic test_reset_mid();
      int strobes = 0, acks = 0;
      logic seen = 1'b0;
      rd_value = 32'hCAFEF00D;
      m0_wr = 1'b0; m0_addr = 32'h3000; m0_req = 1'b1;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         if (mem_memread) seen = 1'b1;
      end
      checks++; if (seen !== 1'b1) begin errors++; $display("FAIL mid_strobe_seen: got 0 required 1"); end
      @(negedge clk);
      hold_stall = 1'b1;
      rst_n = 1'b0;
      @(negedge clk);
      checks++; if (all_out !== '0) begin errors++; $display("FAIL mid_reset_outputs: got %h required 0", all_out); end
      rst_n = 1'b1;
      repeat (8) begin
         @(negedge clk);
         if (mem_memread || mem_memwrite) strobes++;
         if (m0_ack || m1_ack) acks++;
      end
      checks++; if (strobes !== 0) begin errors++; $display("FAIL mid_no_strobe: got %0d required 0", strobes); end
      checks++; if (acks !== 0) begin errors++; $display("FAIL mid_no_ack: got %0d required 0", acks); end
      hold_stall = 1'b0;
      run_txn(0, 1'b0, 32'h3000, 32'h0, 4'h0, 30);
      checks++; if (obs_ack !== 1) begin errors++; $display("FAIL mid_resume_ack: got %0d required 1", obs_ack); end
      checks++; if (obs_lat !== 4) begin errors++; $display("FAIL mid_resume_latency: got %0d required 4", obs_lat); end
      checks++; if (obs_rdata !== 32'hCAFEF00D) begin errors++; $display("FAIL mid_resume_data: got %h required cafef00d", obs_rdata); end
   endtask

   task automatic test_timeout();
      rd_value = 32'h55AA55AA;
      hang = 1'b1;
      run_txn(0, 1'b0, 32'h4000, 32'h0, 4'h0, 40);
`ifdef DATA_MEM_ARB_TIMEOUT_EN
      checks++; if (obs_ack !== 1) begin errors++; $display("FAIL to_ack: got %0d required 1", obs_ack); end
      checks++; if (obs_lat !== 1 + TIMEOUT_CYCLES) begin errors++; $display("FAIL to_latency: got %0d required %0d", obs_lat, 1 + TIMEOUT_CYCLES); end
      checks++; if (obs_err !== 1'b1) begin errors++; $display("FAIL to_err: got %0b required 1", obs_err); end
      checks++; if (obs_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL to_data: got %h required deadbeef", obs_rdata); end
      hang = 1'b0;
      repeat (6) @(negedge clk);
`else
      checks++; if (obs_ack !== 0) begin errors++; $display("FAIL hang_no_ack: got %0d required 0", obs_ack); end
      checks++; if (obs_err_any !== 1'b0) begin errors++; $display("FAIL hang_no_err: got 1 required 0"); end
      hang = 1'b0;
      run_txn(0, 1'b0, 32'h4000, 32'h0, 4'h0, 20);
      checks++; if (obs_ack !== 1) begin errors++; $display("FAIL hang_release_ack: got %0d required 1", obs_ack); end
      checks++; if (obs_rdata !== 32'h55AA55AA) begin errors++; $display("FAIL hang_release_data: got %h required 55aa55aa", obs_rdata); end
      checks++; if (obs_err !== 1'b0) begin errors++; $display("FAIL hang_release_err: got %0b required 0", obs_err); end
`endif
   endtask

   initial begin
      test_reset();
      test_single_read();
      test_single_write();
      test_contention();
      test_reset_mid();
      test_timeout();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/data_mem_arbiter.md
Name: data_mem_arbiter

Overview:
- Shares the single data-memory port between two requesters: port 0 is the CPU load/store unit, port 1 is the DMA/debug loader.
- Sequences each access through the memory's strobe/stall protocol:
  - one-cycle memread/memwrite strobe
  - memory raises clk_stall on the edge that samples the strobe
  - memory drops clk_stall with read_data valid
- Returns data to the winning requester with a one-cycle ack.
- Fixed priority to port 0, with a starvation counter guaranteeing port 1 progress.

Parameters:
- STARVE_LIMIT, 4: consecutive port-0 grants while port 1 waits before port 1 is forced to win; must be ≥1.
- TIMEOUT_CYCLES, 64: BUSY-state cycles before a watchdog abort (only with the macro).

Ports:
- clk  in  1  system clock, all state on posedge
- rst_n  in  1  asynchronous active-low reset
- m0_req  in  1  port 0 request, held with payload until ack
- m0_wr  in  1  1 = write, 0 = read
- m0_addr  in  32  byte address
- m0_wdata  in  32  write data
- m0_mask  in  4  sign_mask encoding, passed through unchanged
- m0_rdata  out  32  read result, valid with m0_ack
- m0_ack  out  1  one-cycle completion pulse
- m0_err  out  1  one-cycle timeout flag, coincident with ack
- m1_req, m1_wr, m1_addr, m1_wdata, m1_mask, m1_rdata, m1_ack, m1_err: same as port 0
- mem_addr  out  32  to memory addr
- mem_write_data  out  32  to memory write_data
- mem_memread  out  1  read strobe
- mem_memwrite  out  1  write strobe
- mem_sign_mask  out  4  to memory sign_mask
- mem_read_data  in  32  from memory read_data
- mem_clk_stall  in  1  memory busy flag

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, starve_cnt=0, grant=0
  - all outputs 0
  - applies mid-transaction with no completion ack
- Memory has no reset. After reset, IDLE does not grant while mem_clk_stall=1, so any in-flight memory access drains first.
- All outputs are registered.
- States: IDLE, ISSUE, BUSY, DONE.
- IDLE (taken when mem_clk_stall=0 and any req=1):
  - Winner:
    - m0 if only m0 requests
    - m1 if only m1 requests
    - both requesting: m1 if starve_cnt==STARVE_LIMIT, else m0
  - Register mem_addr, mem_write_data, mem_sign_mask from the winner's payload.
  - Set mem_memread=~wr and mem_memwrite=wr; latch grant; go to ISSUE.
  - starve_cnt: +1 (saturating) on an m0 grant while m1_req=1; cleared on an m1 grant.
- ISSUE: the strobe is high for exactly this cycle. At the edge, clear both strobes and go to BUSY. Address/data/mask stay held until DONE.
- BUSY:
  - While mem_clk_stall=1: wait.
  - When mem_clk_stall=0:
    - reads: rdata of the granted port <= mem_read_data
    - writes: rdata unchanged
    - ack of the granted port <= 1; go to DONE
- DONE:
  - ack <= 0; go to IDLE.
  - Requests are not sampled in DONE. A requester updates or drops req at the edge where it sees ack=1.
- Latency, from the IDLE edge that grants (edge N) to the edge that raises ack:
  - read: 4 edges; ack high during cycle N+4..N+5
  - write: 3 edges
  - back-to-back service from one port: one request per 6 cycles (read) or 5 cycles (write)
- The non-granted port's outputs never change; ack is never asserted to both ports.
- A request that drops before ack (protocol violation) still completes. Its ack is still issued.
- The err outputs are tied to 0 without the macro.

Optional Feature:
- Macro: DATA_MEM_ARB_TIMEOUT_EN.
- Defined:
  - BUSY counts cycles.
  - If mem_clk_stall is still 1 after TIMEOUT_CYCLES, go to DONE with ack=1, err=1 and rdata=32'hDEADBEEF on the granted port.
  - The next IDLE still waits for mem_clk_stall=0.
- Undefined: no counter; BUSY waits indefinitely; err outputs constant 0.

Decomposition:
- Package data_mem_arb_pkg holds:
  - state encoding constants (IDLE=0, ISSUE=1, BUSY=2, DONE=3)
  - port ids PORT_CPU=0, PORT_DMA=1
  - TIMEOUT_DATA=32'hDEADBEEF
- One sub-module, data_mem_arb_pick: combinational winner selection from m0_req, m1_req, starve_cnt and STARVE_LIMIT. All sequencing stays in the top.

Test Plan:
- Single read: m0 read, addr=32'h1004, memory returns 32'h12345678 → mem_memread high exactly 1 cycle; m0_ack 1 cycle, 4 edges after grant; m0_rdata=32'h12345678; m1_ack stays 0.
- Single write: m1 write, addr=32'h2000, wdata=32'hA5, mask=4'b0100 → mem_memwrite 1 cycle; mem_write_data=32'hA5; mem_sign_mask=4'b0100; m1_ack 3 edges after grant.
- Contention: m0 and m1 request continuously, STARVE_LIMIT=4 → grant order m0,m0,m0,m0,m1, repeating; starve_cnt returns to 0 after each m1 grant.
- Reset mid-access: assert rst_n=0 in BUSY, release while mem_clk_stall=1 → no ack; no strobe until the stall falls; then the pending m0 read completes normally.
- Timeout (macro defined, TIMEOUT_CYCLES=8): hold mem_clk_stall=1 → after 8 BUSY cycles m0_ack=1, m0_err=1, m0_rdata=32'hDEADBEEF. Without the macro, ack never fires.
